// File: rtl/imm_pkg.sv
// Shared types and constants for the pipelined immediate generator:
// format codes, RISC-V major opcodes and the skid-buffer state encoding.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_SH   = 3'd5,
    FMT_NONE = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_IMM32    = 7'b0011011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  // funct3 values that turn an OP-IMM / OP-IMM-32 opcode into a shift
  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extractor: classifies a 32-bit instruction and
// produces its sign- (or zero-, for shift amounts) extended immediate.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm32;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_LOAD, OP_MISC_MEM, OP_JALR: begin
        fmt   = FMT_I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OP_IMM, OP_IMM32: begin
        if (is_shift(funct3)) begin
          fmt = FMT_SH;
          // Only RV64 OP-IMM shifts have a 6-bit shamt; funct6/7 never leak in.
          if (XLEN == 64 && opcode == OP_IMM) imm32 = {26'b0, instr[25:20]};
          else                                imm32 = {27'b0, instr[24:20]};
        end else begin
          fmt   = FMT_I;
          imm32 = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OP_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt   = FMT_J;
        imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: illegal = 1'b1;
    endcase
  end

  // Every format is already correct as a signed 32-bit value; widen from bit 31.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: combinational decode on the input side,
// followed by a 2-entry skid buffer (output register + skid register).
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output imm_fmt_e         out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_fmt_e         fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0, tag: '0};

  buf_state_e      state;
  entry_t          or_q;
  entry_t          sk_q;
  entry_t          in_entry;
  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;
  logic            accept;
  logic            pop;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign in_entry = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, tag: in_tag};

  // A flush kills whatever is offered in the same cycle.
  assign accept = in_valid & in_ready & ~flush;
  assign pop    = out_valid & out_ready;

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  // in_ready/out_valid are their own flops, so in_ready never sees out_ready combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= BUF_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      or_q      <= ENTRY_RESET;
      sk_q      <= ENTRY_RESET;
    end else if (flush) begin
      state     <= BUF_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (accept) begin
            or_q      <= in_entry;
            out_valid <= 1'b1;
            state     <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (accept && pop) begin
            or_q <= in_entry;
          end else if (accept) begin
            sk_q     <= in_entry;
            in_ready <= 1'b0;
            state    <= BUF_FULL;
          end else if (pop) begin
            out_valid <= 1'b0;
            state     <= BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (pop) begin
            or_q     <= sk_q;
            in_ready <= 1'b1;
            state    <= BUF_ONE;
          end
        end
        default: begin
          state     <= BUF_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_imm     = or_q.imm;
  assign out_fmt     = or_q.fmt;
  assign out_illegal = or_q.illegal;
  assign out_tag     = or_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: decode table on XLEN=64 and XLEN=32
// instances, then backpressure, flush and asynchronous reset sequences.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        in_ready, out_valid, out_illegal;
  logic [63:0] out_imm;
  logic [2:0]  out_fmt;
  logic [7:0]  out_tag;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32;
  logic [2:0]  out_fmt32;
  logic [7:0]  out_tag32;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_fmt(out_fmt32), .out_illegal(out_illegal32), .out_tag(out_tag32)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Record every completed transfer of the 64-bit instance, in order.
  logic log_en = 1'b0;
  int   popped[$];
  always @(posedge clk) begin
    if (log_en && out_valid && out_ready) popped.push_back(int'(out_tag));
  end

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm64;
    logic [31:0] imm32;
    logic [2:0]  fmt;
    logic        illegal;
  } vec_t;

  vec_t vecs[16];

  task automatic check_reset_values(input string tag_name);
    check({tag_name, " out_valid"},   64'(out_valid),   64'd0);
    check({tag_name, " in_ready"},    64'(in_ready),    64'd1);
    check({tag_name, " out_imm"},     out_imm,          64'd0);
    check({tag_name, " out_fmt"},     64'(out_fmt),     64'd7);
    check({tag_name, " out_illegal"}, 64'(out_illegal), 64'd0);
    check({tag_name, " out_tag"},     64'(out_tag),     64'd0);
  endtask

  task automatic offer(input logic [7:0] tag, input logic [31:0] instr);
    in_valid = 1'b1;
    in_tag   = tag;
    in_instr = instr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            instr          imm (XLEN=64)           imm (XLEN=32)  fmt   illegal
    vecs[0]  = '{32'hFF813283, 64'hFFFF_FFFF_FFFF_FFF8, 32'hFFFF_FFF8, 3'd0, 1'b0}; // ld x5,-8(x2)
    vecs[1]  = '{32'h00513823, 64'h10,                  32'h10,        3'd1, 1'b0}; // sd x5,16(x2)
    vecs[2]  = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 3'd2, 1'b0}; // beq -4
    vecs[3]  = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 3'd3, 1'b0}; // lui
    vecs[4]  = '{32'h0010006F, 64'h800,                 32'h800,       3'd4, 1'b0}; // jal 2048
    vecs[5]  = '{32'h03F09093, 64'h3F,                  32'h1F,        3'd5, 1'b0}; // slli 63
    vecs[6]  = '{32'h4030D093, 64'h3,                   32'h3,         3'd5, 1'b0}; // srai 3
    vecs[7]  = '{32'h00000000, 64'h0,                   32'h0,         3'd7, 1'b1}; // illegal
    vecs[8]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 3'd0, 1'b0}; // addi -1
    vecs[9]  = '{32'h03F0909B, 64'h1F,                  32'h1F,        3'd5, 1'b0}; // slliw, bit25 set
    vecs[10] = '{32'h00008067, 64'h0,                   32'h0,         3'd0, 1'b0}; // jalr (ret)
    vecs[11] = '{32'h00001017, 64'h1000,                32'h1000,      3'd3, 1'b0}; // auipc
    vecs[12] = '{32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 3'd1, 1'b0}; // sw -4
    vecs[13] = '{32'h002081B3, 64'h0,                   32'h0,         3'd7, 1'b1}; // add (R-type)
    vecs[14] = '{32'h7FF0809B, 64'h7FF,                 32'h7FF,       3'd0, 1'b0}; // addiw 2047
    vecs[15] = '{32'hFFDFF06F, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 3'd4, 1'b0}; // j -4

    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Decode table, streamed back to back with the consumer always ready.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      offer(8'(i + 16), vecs[i].instr);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d out_valid", i),     64'(out_valid),     64'd1);
      check($sformatf("vec%0d imm64", i),         out_imm,            vecs[i].imm64);
      check($sformatf("vec%0d fmt", i),           64'(out_fmt),       64'(vecs[i].fmt));
      check($sformatf("vec%0d illegal", i),       64'(out_illegal),   64'(vecs[i].illegal));
      check($sformatf("vec%0d tag", i),           64'(out_tag),       64'(i + 16));
      check($sformatf("vec%0d imm32", i),         64'(out_imm32),     64'(vecs[i].imm32));
      check($sformatf("vec%0d fmt32", i),         64'(out_fmt32),     64'(vecs[i].fmt));
      check($sformatf("vec%0d illegal32", i),     64'(out_illegal32), 64'(vecs[i].illegal));
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("drain out_valid", 64'(out_valid), 64'd0);

    // Backpressure: tags 1..4 offered back to back, consumer stalled.
    @(negedge clk);
    popped.delete();
    log_en    = 1'b1;
    out_ready = 1'b0;
    offer(8'd1, 32'hFF813283);
    @(posedge clk); #1;
    check("bp1 out_tag",  64'(out_tag),  64'd1);
    check("bp1 in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    offer(8'd2, 32'h00513823);
    @(posedge clk); #1;
    check("bp2 in_ready", 64'(in_ready), 64'd0);
    check("bp2 out_tag",  64'(out_tag),  64'd1);
    @(negedge clk);
    offer(8'd3, 32'hFE000EE3);
    @(posedge clk); #1;
    check("bp3 in_ready stall", 64'(in_ready), 64'd0);
    check("bp3 out_tag held",   64'(out_tag),  64'd1);
    check("bp3 out_imm held",   out_imm,       64'hFFFF_FFFF_FFFF_FFF8);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp4 out_tag", 64'(out_tag), 64'd2);
    @(negedge clk);
    @(posedge clk); #1;
    check("bp5 out_tag", 64'(out_tag), 64'd3);
    @(negedge clk);
    offer(8'd4, 32'h0010006F);
    @(posedge clk); #1;
    check("bp6 out_tag", 64'(out_tag), 64'd4);
    check("bp6 out_imm", out_imm,      64'h800);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp drained", 64'(out_valid), 64'd0);
    check("bp pop count", 64'(popped.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("bp order %0d", i),
            64'((i < popped.size()) ? popped[i] : -1), 64'(i + 1));

    // Flush in FULL with an input offered and a pop in the same cycle.
    @(negedge clk);
    popped.delete();
    out_ready = 1'b0;
    offer(8'd5, 32'h800000B7);
    @(posedge clk);
    @(negedge clk);
    offer(8'd6, 32'h03F09093);
    @(posedge clk); #1;
    check("fl full in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    offer(8'd7, 32'h4030D093);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("fl out_valid", 64'(out_valid), 64'd0);
    check("fl in_ready",  64'(in_ready),  64'd1);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("fl input absent", 64'(out_valid), 64'd0);
    check("fl pop count",    64'(popped.size()), 64'd1);
    check("fl popped tag",   64'((popped.size() > 0) ? popped[0] : -1), 64'd5);

    // Asynchronous reset in the middle of a cycle with an entry held.
    @(negedge clk);
    out_ready = 1'b0;
    offer(8'd9, 32'hFFF00093);
    @(posedge clk); #1;
    check("rst pre out_tag", 64'(out_tag), 64'd9);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("async reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post reset out_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the decode stage. Accepts a 32-bit RISC-V instruction plus a sideband tag under valid/ready handshake, classifies its format (I, shift-I, S, B, U, J), produces the sign-extended immediate at XLEN width, and flags opcodes that carry no immediate. The output is registered behind a 2-entry skid buffer, so decode can stall without a combinational ready path. Supersedes the load/store/branch-only extractor.

## Interface
- `XLEN`, 64, immediate width; legal values 32 or 64.
- `TAG_W`, 8, width of the opaque tag carried alongside each instruction (PC index / ROB id).

- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill of all buffered entries.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  registered; block can accept.
- `in_instr`  in  32  instruction word.
- `in_tag`  in  TAG_W  sideband tag.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts.
- `out_imm`  out  XLEN  immediate.
- `out_fmt`  out  3  format code (`imm_fmt_e`).
- `out_illegal`  out  1  opcode has no immediate format.
- `out_tag`  out  TAG_W  tag of the presented result.

## Operation
- Decode is on `in_instr[6:0]`:
  - I: 0000011, 0001111, 1100111, and 0010011/0011011 except shifts. Imm = sext(`[31:20]`).
  - SH: 0010011 or 0011011 with funct3 001/101. Imm = zext(shamt).
    - shamt = `[25:20]` when XLEN=64 and opcode is 0010011.
    - shamt = `[24:20]` otherwise.
    - funct6/funct7 bits are never part of the immediate.
  - S: 0100011. Imm = sext(`{[31:25],[11:7]}`).
  - B: 1100011. Imm = sext(`{[31],[7],[30:25],[11:8],1'b0}`), a byte offset with bit0 = 0.
  - U: 0110111, 0010111. Imm = sext(`{[31:12],12'b0}`) from bit 31.
  - J: 1101111. Imm = sext(`{[31],[19:12],[20],[30:21],1'b0}`).
  - Any other opcode: `FMT_NONE`, imm = 0, `out_illegal` = 1.
- Buffer states, counting occupied entries (output register OR, skid register SK):
  - EMPTY: `in_ready`=1, `out_valid`=0. Accept → ONE.
  - ONE: `out_valid`=1, `in_ready`=1.
    - Accept with `out_ready` → stays ONE; OR reloads with the new entry.
    - Accept without `out_ready` → FULL; new entry goes to SK.
    - No accept with `out_ready` → EMPTY.
  - FULL: `in_ready`=0. `out_ready` → ONE; SK moves into OR.
- Accept = `in_valid & in_ready`. Pop = `out_valid & out_ready`.
- Order is strictly FIFO. Sustained throughput is 1 per cycle.
- `flush`:
  - Next state is EMPTY. An input offered in the same cycle is dropped, even if `in_ready`=1.
  - A pop in the flush cycle still completes for the consumer.
- `out_*` data is held stable while `out_valid & !out_ready`.

## Timing
- Latency: an accepted instruction appears at `out_*` on the next rising edge when OR is empty or popping.
- Reset values: `out_valid`=0, `in_ready`=1, `out_imm`=0, `out_fmt`=`FMT_NONE`, `out_illegal`=0, `out_tag`=0. The state is EMPTY.
- Reset asserted mid-transfer discards both entries immediately; no partial output is ever presented.
- `in_ready` depends only on state, never on `out_ready` in the same cycle.
- Simultaneous accept and pop in FULL cannot occur, because `in_ready`=0.
- Data registers load only on accept or shift, not every cycle.

## Structure
- Package `imm_pkg`:
  - `imm_fmt_e` encoding: `FMT_I`=0, `FMT_S`=1, `FMT_B`=2, `FMT_U`=3, `FMT_J`=4, `FMT_SH`=5, `FMT_NONE`=7.
  - 7-bit opcode constants.
  - Buffer state enum.
- Sub-module `imm_decode`: purely combinational, parametrised by XLEN, maps `instr` to `{imm, fmt, illegal}`. It is instantiated once on the input side.
- `imm_gen_pipe` holds the 2-entry buffer, its control logic, and the tag path.

## Test plan
- I-type: `ld x5,-8(x2)` = 0xFF813283 → next cycle `out_valid`=1, imm 0xFFFF_FFFF_FFFF_FFF8, fmt I, tag echoed.
- S- and B-type:
  - `sd x5,16(x2)` = 0x00513823 → imm 0x10, fmt S.
  - `beq x0,x0,-4` = 0xFE000EE3 → imm 0xFFFF_FFFF_FFFF_FFFC, fmt B.
- U-, J- and shift-type:
  - `lui` 0x800000B7 → imm 0xFFFF_FFFF_8000_0000.
  - `jal x0,2048` = 0x0010006F → imm 0x800, fmt J.
  - `slli x1,x1,63` = 0x03F09093 → imm 0x3F, fmt SH.
  - `srai x1,x1,3` = 0x4030D093 → imm 0x3.
- Illegal: 0x00000000 → fmt NONE, imm 0, `out_illegal`=1. Repeat with XLEN=32 for the `lui` and `slli` vectors: `lui` → 0x8000_0000; `slli` shamt is 5 bits.
- Backpressure:
  - Drive 4 back-to-back inputs, tags 1–4, with `out_ready`=0.
  - Expect tags 1 and 2 accepted and `in_ready`=0 from the cycle after the second accept.
  - Release `out_ready`: tags 1, 2, 3, 4 delivered in order with no loss or duplication.
- Flush and reset:
  - In FULL, assert `flush` together with `in_valid` → next cycle `out_valid`=0, `in_ready`=1, offered input absent.
  - Assert `reset_n`=0 asynchronously mid-stream → outputs return to reset values immediately.
